// File: rtl/elevator_pkg.sv
// Shared types, call-bit layout and scheduling helpers for the elevator call scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    FLOOR_NONE = 2'b00,
    FLOOR1     = 2'b01,
    FLOOR2     = 2'b10,
    FLOOR3     = 2'b11
  } floor_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    TRAVEL,
    DWELL
  } sched_state_t;

  // Call/lamp bit layout: {f3,f2,f1,d3,d2,u2,u1}
  localparam int NUM_CALLS = 7;
  localparam int LAMP_U1   = 0;
  localparam int LAMP_U2   = 1;
  localparam int LAMP_D2   = 2;
  localparam int LAMP_D3   = 3;
  localparam int LAMP_F1   = 4;
  localparam int LAMP_F2   = 5;
  localparam int LAMP_F3   = 6;

  // Groupings of call bits by floor and by kind
  localparam logic [NUM_CALLS-1:0] FLOOR1_CALLS = 7'b0010001;
  localparam logic [NUM_CALLS-1:0] FLOOR2_CALLS = 7'b0100110;
  localparam logic [NUM_CALLS-1:0] FLOOR3_CALLS = 7'b1001000;
  localparam logic [NUM_CALLS-1:0] CAR_CALLS    = 7'b1110000;
  localparam logic [NUM_CALLS-1:0] UP_CALLS     = 7'b0000011;
  localparam logic [NUM_CALLS-1:0] DOWN_CALLS   = 7'b0001100;
  localparam logic [NUM_CALLS-1:0] END_CALLS    = 7'b0001001;

  typedef struct packed {
    floor_t floor;
    dir_t   dir;
    dir_t   next_dir;
  } target_t;

  // Per-floor vectors use bit 0 = floor 1 .. bit 2 = floor 3
  function automatic floor_t lowest_floor(input logic [2:0] v);
    if (v[0])      return FLOOR1;
    else if (v[1]) return FLOOR2;
    else           return FLOOR3;
  endfunction

  function automatic floor_t highest_floor(input logic [2:0] v);
    if (v[2])      return FLOOR3;
    else if (v[1]) return FLOOR2;
    else           return FLOOR1;
  endfunction

  // SCAN target: keep going the current way, else reverse, else serve here
  function automatic target_t pick_target(input logic [NUM_CALLS-1:0] calls,
                                          input floor_t cur, input dir_t dir);
    logic [2:0] car, up, dn, any_call, here, above, below;
    logic [2:0] up_near, up_far, dn_near, dn_far;
    logic       go_up, go_down;
    target_t    t;
    car      = calls[LAMP_F3:LAMP_F1];
    up       = {1'b0, calls[LAMP_U2], calls[LAMP_U1]};
    dn       = {calls[LAMP_D3], calls[LAMP_D2], 1'b0};
    any_call = car | up | dn;
    case (cur)
      FLOOR1:  begin here = 3'b001; above = 3'b110; below = 3'b000; end
      FLOOR2:  begin here = 3'b010; above = 3'b100; below = 3'b001; end
      default: begin here = 3'b100; above = 3'b000; below = 3'b011; end
    endcase
    up_near = (car | up) & above;
    up_far  = dn & above;
    dn_near = (car | dn) & below;
    dn_far  = up & below;
    go_up   = |{up_near, up_far};
    go_down = |{dn_near, dn_far};

    t.floor    = cur;
    t.dir      = DIR_NONE;
    t.next_dir = dir;
    if (dir == DIR_NONE) begin
      if (!(|(any_call & here))) begin
        t.floor    = lowest_floor(any_call);
        t.dir      = (t.floor > cur) ? DIR_UP : DIR_DOWN;
        t.next_dir = t.dir;
      end
    end else if ((dir == DIR_UP && go_up) || (dir == DIR_DOWN && !go_down && go_up)) begin
      t.floor    = (|up_near) ? lowest_floor(up_near) : highest_floor(up_far);
      t.dir      = DIR_UP;
      t.next_dir = DIR_UP;
    end else if (go_down) begin
      t.floor    = (|dn_near) ? highest_floor(dn_near) : lowest_floor(dn_far);
      t.dir      = DIR_DOWN;
      t.next_dir = DIR_DOWN;
    end
    return t;
  endfunction

  // Calls satisfied by stopping at floor f while heading d
  function automatic logic [NUM_CALLS-1:0] served_mask(input logic [NUM_CALLS-1:0] calls,
                                                       input floor_t f, input dir_t d);
    logic [NUM_CALLS-1:0] at_floor, above, below, m;
    case (f)
      FLOOR1:  begin at_floor = FLOOR1_CALLS; above = FLOOR2_CALLS | FLOOR3_CALLS; below = '0; end
      FLOOR2:  begin at_floor = FLOOR2_CALLS; above = FLOOR3_CALLS; below = FLOOR1_CALLS; end
      default: begin at_floor = FLOOR3_CALLS; above = '0; below = FLOOR1_CALLS | FLOOR2_CALLS; end
    endcase
    case (d)
      DIR_UP: begin
        m = at_floor & (CAR_CALLS | UP_CALLS);
        if (!(|(calls & above))) m = m | (at_floor & DOWN_CALLS);
      end
      DIR_DOWN: begin
        m = at_floor & (CAR_CALLS | DOWN_CALLS);
        if (!(|(calls & below))) m = m | (at_floor & UP_CALLS);
      end
      default: m = at_floor;
    endcase
    return m | (at_floor & END_CALLS);
  endfunction

endpackage

// File: rtl/elevator_call_latch.sv
// Rising-edge detection and set/clear holding registers for the seven calls.
module elevator_call_latch
  import elevator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CALLS-1:0] buttons,
  input  logic [NUM_CALLS-1:0] clr,
  output logic [NUM_CALLS-1:0] lamps
);

  logic [NUM_CALLS-1:0] btn_q;
  logic [NUM_CALLS-1:0] rise;

  assign rise = buttons & ~btn_q;

  // Track button history and hold calls; a same-cycle press beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= '0;
      lamps <= '0;
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values of the others.
      btn_q <= buttons;
      lamps <= (lamps & ~clr) | rise;
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches calls, picks targets, and handshakes one command at a time.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       u1,
  input  logic       u2,
  input  logic       d2,
  input  logic       d3,
  input  logic       f1,
  input  logic       f2,
  input  logic       f3,
  input  logic [1:0] fs,
  input  logic       cmd_ready,
  input  logic       arrive,
  output logic       cmd_valid,
  output logic [1:0] cmd_floor,
  output logic [1:0] cmd_dir,
  output logic [6:0] lamps
);

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  sched_state_t         state;
  floor_t               cur_floor;
  floor_t               cmd_floor_r;
  dir_t                 cur_dir;
  dir_t                 cmd_dir_r;
  logic [7:0]           dwell_cnt;
  logic [NUM_CALLS-1:0] buttons;
  logic [NUM_CALLS-1:0] clr_mask;
  target_t              next_target;
  logic                 calls_pending;

  assign buttons       = {f3, f2, f1, d3, d2, u2, u1};
  assign calls_pending = |lamps;
  assign next_target   = pick_target(lamps, cur_floor, cur_dir);
  assign cmd_floor     = cmd_floor_r;
  assign cmd_dir       = cmd_dir_r;

  elevator_call_latch u_call_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .buttons (buttons),
    .clr     (clr_mask),
    .lamps   (lamps)
  );

  // Clear mask is only live on the arrive cycle of a trip
  always_comb begin
    // NOTE: default first so no path leaves clr_mask unassigned, avoiding a latch.
    clr_mask = '0;
    if (state == TRAVEL && arrive) clr_mask = served_mask(lamps, cmd_floor_r, cmd_dir_r);
  end

  // Last known floor; holds while the car is between floors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cur_floor <= FLOOR1;
    else if (fs != 2'b00)    cur_floor <= floor_t'(fs);
  end

  // Scheduler FSM with registered command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_valid   <= 1'b0;
      cmd_floor_r <= FLOOR1;
      cmd_dir_r   <= DIR_NONE;
      cur_dir     <= DIR_NONE;
      dwell_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (calls_pending) begin
            cmd_valid   <= 1'b1;
            cmd_floor_r <= next_target.floor;
            cmd_dir_r   <= next_target.dir;
            cur_dir     <= next_target.next_dir;
            state       <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= TRAVEL;
          end
        end
        TRAVEL: begin
          if (arrive) begin
            dwell_cnt <= DWELL_LOAD;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (dwell_cnt != 8'd0) begin
            dwell_cnt <= dwell_cnt - 8'd1;
          end else if (calls_pending) begin
            cmd_valid   <= 1'b1;
            cmd_floor_r <= next_target.floor;
            cmd_dir_r   <= next_target.dir;
            cur_dir     <= next_target.next_dir;
            state       <= DISPATCH;
          end else begin
            cur_dir <= DIR_NONE;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed and randomized checks of the elevator call scheduler against a call-list model.
module tb_elevator_call_scheduler;
  import elevator_pkg::*;

  localparam int DWELL = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] btn;
  logic [1:0] fs;
  logic       cmd_ready;
  logic       arrive;
  logic       cmd_valid;
  logic [1:0] cmd_floor;
  logic [1:0] cmd_dir;
  logic [6:0] lamps;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: pending calls per floor, car position and sweep direction
  bit car_m[1:3];
  bit up_m[1:3];
  bit dn_m[1:3];
  int mf;
  int md; // 0 none, 1 up, 2 down

  elevator_call_scheduler #(.DWELL_CYCLES(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .u1        (btn[0]),
    .u2        (btn[1]),
    .d2        (btn[2]),
    .d3        (btn[3]),
    .f1        (btn[4]),
    .f2        (btn[5]),
    .f3        (btn[6]),
    .fs        (fs),
    .cmd_ready (cmd_ready),
    .arrive    (arrive),
    .cmd_valid (cmd_valid),
    .cmd_floor (cmd_floor),
    .cmd_dir   (cmd_dir),
    .lamps     (lamps)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit floor_has_call(input int f);
    return car_m[f] || up_m[f] || dn_m[f];
  endfunction

  function automatic bit model_pending();
    return floor_has_call(1) || floor_has_call(2) || floor_has_call(3);
  endfunction

  function automatic logic [6:0] model_lamps();
    return {car_m[3], car_m[2], car_m[1], dn_m[3], dn_m[2], up_m[2], up_m[1]};
  endfunction

  task automatic model_set(input logic [6:0] m);
    if (m[0]) up_m[1] = 1;
    if (m[1]) up_m[2] = 1;
    if (m[2]) dn_m[2] = 1;
    if (m[3]) dn_m[3] = 1;
    if (m[4]) car_m[1] = 1;
    if (m[5]) car_m[2] = 1;
    if (m[6]) car_m[3] = 1;
  endtask

  // Look for a stop in direction d (1 up, 2 down) from the model floor
  function automatic bit scan(input int d, output int tf);
    tf = mf;
    if (d == 1) begin
      for (int f = mf + 1; f <= 3; f++) if (car_m[f] || up_m[f]) begin tf = f; return 1; end
      for (int f = 3; f > mf; f--)      if (dn_m[f])              begin tf = f; return 1; end
    end else begin
      for (int f = mf - 1; f >= 1; f--) if (car_m[f] || dn_m[f]) begin tf = f; return 1; end
      for (int f = 1; f < mf; f++)      if (up_m[f])              begin tf = f; return 1; end
    end
    return 0;
  endfunction

  task automatic model_pick(output int tf, output int td);
    int s;
    tf = mf;
    td = 0;
    if (md == 0) begin
      if (!floor_has_call(mf)) begin
        for (int f = 3; f >= 1; f--) if (floor_has_call(f)) tf = f;
        td = (tf > mf) ? 1 : 2;
        md = td;
      end
    end else if (scan(md, s)) begin
      tf = s;
      td = md;
    end else if (scan(3 - md, s)) begin
      tf = s;
      td = 3 - md;
      md = td;
    end
  endtask

  task automatic model_clear(input int f, input int d);
    bit beyond = 0;
    if (d == 0) begin
      car_m[f] = 0; up_m[f] = 0; dn_m[f] = 0;
    end else if (d == 1) begin
      for (int g = f + 1; g <= 3; g++) if (floor_has_call(g)) beyond = 1;
      car_m[f] = 0; up_m[f] = 0;
      if (!beyond) dn_m[f] = 0;
    end else begin
      for (int g = 1; g < f; g++) if (floor_has_call(g)) beyond = 1;
      car_m[f] = 0; dn_m[f] = 0;
      if (!beyond) up_m[f] = 0;
    end
    if (f == 1) up_m[1] = 0;
    if (f == 3) dn_m[3] = 0;
  endtask

  initial begin
    int tf, td, k;
    bit pend;
    logic [6:0] r;

    btn = '0; fs = 2'b01; cmd_ready = 0; arrive = 0; rst_n = 0;
    step(); step();
    check("reset_valid", cmd_valid, 0);
    check("reset_floor", cmd_floor, 2'b01);
    check("reset_dir", cmd_dir, 2'b00);
    check("reset_lamps", lamps, 0);
    rst_n = 1;
    step();

    // f3 from floor 1, stall with d2 pressed, pass floor 2, arrive at 3
    btn[LAMP_F3] = 1; step(); btn = '0;
    check("f3_lamp", lamps, 7'b1000000);
    step();
    check("f3_valid", cmd_valid, 1);
    check("f3_floor", cmd_floor, 2'b11);
    check("f3_dir", cmd_dir, 2'b01);
    for (int i = 0; i < 5; i++) begin
      btn[LAMP_D2] = (i == 0);
      step();
      check("stall_valid", cmd_valid, 1);
      check("stall_floor", cmd_floor, 2'b11);
      check("stall_dir", cmd_dir, 2'b01);
    end
    btn = '0;
    check("stall_lamps", lamps, 7'b1000100);
    cmd_ready = 1; step(); cmd_ready = 0;
    check("accept_drop", cmd_valid, 0);
    fs = 2'b00; step(); fs = 2'b10; step(); fs = 2'b00; step();
    check("pass_f2_keeps_d2", lamps, 7'b1000100);
    fs = 2'b11; step();
    arrive = 1; step(); arrive = 0;
    check("arrive3_lamps", lamps, 7'b0000100);
    for (int j = 1; j < DWELL; j++) begin step(); check("dwell_quiet", cmd_valid, 0); end
    step();
    check("d2_valid", cmd_valid, 1);
    check("d2_floor", cmd_floor, 2'b10);
    check("d2_dir", cmd_dir, 2'b10);
    cmd_ready = 1; step(); cmd_ready = 0;
    fs = 2'b00; step(); fs = 2'b10; step();
    arrive = 1; step(); arrive = 0;
    check("arrive2_lamps", lamps, 0);
    for (int j = 0; j < DWELL + 2; j++) begin step(); check("idle_after_dwell", cmd_valid, 0); end

    // u2 at floor 2 while idle: serve in place; held button must not re-latch
    btn[LAMP_U2] = 1; step();
    check("u2_lamp", lamps, 7'b0000010);
    step();
    check("u2_valid", cmd_valid, 1);
    check("u2_floor", cmd_floor, 2'b10);
    check("u2_dir", cmd_dir, 2'b00);
    cmd_ready = 1; step(); cmd_ready = 0;
    arrive = 1; step(); arrive = 0;
    check("u2_cleared", lamps, 0);
    for (int j = 0; j < 20; j++) begin step(); check("u2_held_no_relatch", lamps, 0); end
    check("u2_held_no_cmd", cmd_valid, 0);
    btn = '0;

    // u1 pressed on the very cycle its clear happens
    fs = 2'b01; step();
    btn[LAMP_U1] = 1; step(); btn = '0;
    check("u1_lamp", lamps, 7'b0000001);
    step();
    check("u1_valid", cmd_valid, 1);
    check("u1_floor", cmd_floor, 2'b01);
    check("u1_dir", cmd_dir, 2'b00);
    cmd_ready = 1; step(); cmd_ready = 0;
    step();
    btn[LAMP_U1] = 1; arrive = 1; step(); btn = '0; arrive = 0;
    check("set_beats_clear", lamps, 7'b0000001);
    for (int j = 1; j < DWELL; j++) step();
    step();
    check("u1_again_valid", cmd_valid, 1);
    check("u1_again_floor", cmd_floor, 2'b01);
    cmd_ready = 1; step(); cmd_ready = 0;
    arrive = 1; step(); arrive = 0;
    check("u1_again_cleared", lamps, 0);
    for (int j = 0; j < DWELL + 1; j++) step();

    // Asynchronous reset while a command is offered, then while travelling
    btn[LAMP_F2] = 1; step(); btn = '0; step();
    check("f2_valid", cmd_valid, 1);
    #2 rst_n = 0; #1;
    check("rst_dispatch_valid", cmd_valid, 0);
    check("rst_dispatch_lamps", lamps, 0);
    #1 rst_n = 1;
    step();
    btn[LAMP_F2] = 1; step(); btn = '0; step();
    check("f2_floor", cmd_floor, 2'b10);
    check("f2_dir", cmd_dir, 2'b01);
    cmd_ready = 1; step(); cmd_ready = 0;
    fs = 2'b00; step();
    check("travel_lamps", lamps, 7'b0100000);
    #2 rst_n = 0; #1;
    check("rst_travel_lamps", lamps, 0);
    check("rst_travel_valid", cmd_valid, 0);
    check("rst_travel_floor", cmd_floor, 2'b01);
    #1 rst_n = 1;
    fs = 2'b10; step();
    arrive = 1; step(); arrive = 0;
    check("arrive_ignored_lamps", lamps, 0);
    for (int j = 0; j < 4; j++) begin step(); check("arrive_ignored_valid", cmd_valid, 0); end
    fs = 2'b01; step();

    // Randomized trips against the model
    for (int f = 1; f <= 3; f++) begin car_m[f] = 0; up_m[f] = 0; dn_m[f] = 0; end
    mf = 1; md = 0;
    for (int it = 0; it < 40; it++) begin
      if (!model_pending()) begin
        r = 7'($urandom_range(1, 127));
        btn = r; model_set(r); step(); btn = '0;
        check("rnd_press_lamps", lamps, model_lamps());
        step();
      end
      model_pick(tf, td);
      check("rnd_valid", cmd_valid, 1);
      check("rnd_floor", cmd_floor, tf);
      check("rnd_dir", cmd_dir, td);
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        step();
        check("rnd_hold_floor", cmd_floor, tf);
        check("rnd_hold_dir", cmd_dir, td);
      end
      cmd_ready = 1; step(); cmd_ready = 0;
      check("rnd_accept", cmd_valid, 0);
      if (tf != mf) begin fs = 2'b00; step(); end
      r = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : 7'd0;
      btn = r; model_set(r); step(); btn = '0;
      check("rnd_travel_lamps", lamps, model_lamps());
      step();
      fs = 2'(tf); step();
      r = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
      arrive = 1; btn = r;
      model_clear(tf, td); model_set(r); mf = tf;
      step(); arrive = 0; btn = '0;
      check("rnd_arrive_lamps", lamps, model_lamps());
      for (int j = 1; j < DWELL; j++) begin step(); check("rnd_dwell_quiet", cmd_valid, 0); end
      step();
      pend = model_pending();
      check("rnd_dwell_exit", cmd_valid, {31'd0, pend});
      if (!pend) md = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
